// File: rtl/conv_frame_seq_if.sv
// Source-read, datapath and destination-write signals of the frame sequencer.
// The sequencer drives the master side; buffers and datapath sit on the slave side.
interface conv_frame_seq_if #(
  parameter int ADDR_W = 16
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        pxl_out;
  logic              pxl_vld;
  logic [7:0]        res_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_eol;
  logic              wr_eof;

  modport master (
    output rd_en, rd_addr, pxl_out, pxl_vld, wr_en, wr_addr, wr_data, wr_eol, wr_eof,
    input  rd_data, res_in
  );

  modport slave (
    input  rd_en, rd_addr, pxl_out, pxl_vld, wr_en, wr_addr, wr_data, wr_eol, wr_eof,
    output rd_data, res_in
  );
endinterface

// File: rtl/conv_frame_seq.sv
// Start-triggered raster sequencer feeding the 1x1 convolution datapath and storing its results.
// Optional busy/hold statistics counters are enabled by defining CONV_FRAME_SEQ_STATS_EN.
module conv_frame_seq #(
  parameter int W      = 220,
  parameter int H      = 220,
  parameter int LAT    = 2,
  parameter int ADDR_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic hold,
  output logic busy,
  output logic done,
  conv_frame_seq_if.master bus
`ifdef CONV_FRAME_SEQ_STATS_EN
  ,
  output logic [23:0] cyc_cnt,
  output logic [15:0] hold_cnt
`endif
);

  localparam int NPIX = W * H;
  localparam int CW   = (W > 1) ? $clog2(W) : 1;
  localparam int RW   = (H > 1) ? $clog2(H) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [CW-1:0]     LAST_COL  = CW'(W - 1);
  localparam logic [RW-1:0]     LAST_ROW  = RW'(H - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              vld_q;
  logic [LAT-1:0]    vld_sr;
  logic              accept, rd_fire, wr_fire;

  assign accept  = (state == IDLE) && start;
  assign rd_fire = (state == FEED) && !hold;
  assign wr_fire = vld_sr[LAT-1];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FEED;
      FEED:    if (rd_fire && rd_addr_q == LAST_ADDR) state_next = DRAIN;
      DRAIN:   if (wr_fire && wr_addr_q == LAST_ADDR) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign bus.rd_en   = rd_fire;
  assign bus.rd_addr = rd_addr_q;
  assign bus.pxl_vld = vld_q;
  assign bus.pxl_out = vld_q ? bus.rd_data : 8'd0;
  assign bus.wr_en   = wr_fire;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_fire ? bus.res_in : 8'd0;
  assign bus.wr_eol  = wr_fire && (col == LAST_COL);
  assign bus.wr_eof  = wr_fire && (wr_addr_q == LAST_ADDR);

  // The valid shift register mirrors the datapath pipeline, so clearing it on
  // reset suppresses writes for pixels that were already in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      vld_sr <= '0;
    end else begin
      vld_q     <= rd_fire;
      vld_sr[0] <= vld_q;
      for (int i = 1; i < LAT; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      col       <= '0;
      row       <= '0;
    end else begin
      if (rd_fire && rd_addr_q != LAST_ADDR) rd_addr_q <= rd_addr_q + ADDR_W'(1);
      if (wr_fire) begin
        if (wr_addr_q != LAST_ADDR) wr_addr_q <= wr_addr_q + ADDR_W'(1);
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

`ifdef CONV_FRAME_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      cyc_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      if (busy && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 24'd1;
      if (state == FEED && hold && hold_cnt != '1) hold_cnt <= hold_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_frame_seq.sv
// Directed bench for conv_frame_seq: a 4x3 LAT=2 frame with a write scoreboard,
// plus 2x2 instances at LAT=1 and LAT=8 for latency sweeps.
module tb_conv_frame_seq;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        eol;
    logic        eof;
  } wr_t;

  logic clk = 1'b0;
  logic reset, start, hold;
  int   cyc = 0, t0 = 0, checks = 0, failures = 0;
  int   idx_b = 0, idx_c = 0;
  wr_t  sb[$];

  logic [63:0] rd_map, wr_map, busy_map, done_map;
  logic [63:0] wr_map_b, done_map_b, busy_map_b, wr_map_c, done_map_c, busy_map_c;

  logic busy_a, done_a, busy_b, done_b, busy_c, done_c;
`ifdef CONV_FRAME_SEQ_STATS_EN
  logic [23:0] cyc_a, cyc_b, cyc_c;
  logic [15:0] hc_a, hc_b, hc_c;
`endif

  conv_frame_seq_if #(.ADDR_W(16)) bus_a ();
  conv_frame_seq_if #(.ADDR_W(16)) bus_b ();
  conv_frame_seq_if #(.ADDR_W(16)) bus_c ();

  conv_frame_seq #(.W(4), .H(3), .LAT(2), .ADDR_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .busy(busy_a), .done(done_a), .bus(bus_a)
`ifdef CONV_FRAME_SEQ_STATS_EN
    , .cyc_cnt(cyc_a), .hold_cnt(hc_a)
`endif
  );

  conv_frame_seq #(.W(2), .H(2), .LAT(1), .ADDR_W(16)) dut_b (
    .clk(clk), .reset(reset), .start(start), .hold(1'b0),
    .busy(busy_b), .done(done_b), .bus(bus_b)
`ifdef CONV_FRAME_SEQ_STATS_EN
    , .cyc_cnt(cyc_b), .hold_cnt(hc_b)
`endif
  );

  conv_frame_seq #(.W(2), .H(2), .LAT(8), .ADDR_W(16)) dut_c (
    .clk(clk), .reset(reset), .start(start), .hold(1'b0),
    .busy(busy_c), .done(done_c), .bus(bus_c)
`ifdef CONV_FRAME_SEQ_STATS_EN
    , .cyc_cnt(cyc_c), .hold_cnt(hc_c)
`endif
  );

  always #5 clk = ~clk;

  // Source buffers hold i+1 at address i; the datapath is a pure LAT-cycle delay.
  logic [7:0] dp_a [2];
  logic [7:0] dp_b;
  logic [7:0] dp_c [8];

  always @(posedge clk) begin
    cyc           <= cyc + 1;
    bus_a.rd_data <= bus_a.rd_addr[7:0] + 8'd1;
    bus_b.rd_data <= bus_b.rd_addr[7:0] + 8'd1;
    bus_c.rd_data <= bus_c.rd_addr[7:0] + 8'd1;
    dp_a[0]       <= bus_a.pxl_out;
    dp_a[1]       <= dp_a[0];
    dp_b          <= bus_b.pxl_out;
    dp_c[0]       <= bus_c.pxl_out;
    for (int i = 1; i < 8; i++) dp_c[i] <= dp_c[i-1];
  end

  assign bus_a.res_in = dp_a[1];
  assign bus_b.res_in = dp_b;
  assign bus_c.res_in = dp_c[7];

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int rel);
    while (cyc - t0 < rel) tick();
  endtask

  task automatic push_frame();
    for (int i = 0; i < 12; i++)
      sb.push_back('{addr: 16'(i), data: 8'(i + 1), eol: (i % 4 == 3), eof: (i == 11)});
  endtask

  task automatic apply_stimulus();
    t0       = cyc;
    rd_map   = '0; wr_map   = '0; busy_map   = '0; done_map   = '0;
    wr_map_b = '0; done_map_b = '0; busy_map_b = '0;
    wr_map_c = '0; done_map_c = '0; busy_map_c = '0;
    idx_b    = 0;
    idx_c    = 0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic pulse_start_at(input int rel);
    wait_until(rel);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_zero_a(input string tag);
    check_output(tag, 64'({busy_a, done_a, bus_a.rd_en, bus_a.rd_addr, bus_a.pxl_vld,
                           bus_a.pxl_out, bus_a.wr_en, bus_a.wr_addr, bus_a.wr_data,
                           bus_a.wr_eol, bus_a.wr_eof}), 64'd0);
  endtask

  // Per-cycle monitor: event maps relative to the last start, write scoreboards.
  initial forever begin : monitor
    int  rel, a;
    wr_t got, want;
    @(negedge clk);
    rel = cyc - t0;
    if (rel >= 0 && rel < 64) begin
      rd_map[rel]     = bus_a.rd_en;
      wr_map[rel]     = bus_a.wr_en;
      busy_map[rel]   = busy_a;
      done_map[rel]   = done_a;
      wr_map_b[rel]   = bus_b.wr_en;
      done_map_b[rel] = done_b;
      busy_map_b[rel] = busy_b;
      wr_map_c[rel]   = bus_c.wr_en;
      done_map_c[rel] = done_c;
      busy_map_c[rel] = busy_c;
    end
    if (bus_a.wr_en) begin
      check_output("sb_has_entry", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        got  = {bus_a.wr_addr, bus_a.wr_data, bus_a.wr_eol, bus_a.wr_eof};
        want = sb.pop_front();
        check_output("wr_beat", 64'(got), 64'(want));
      end
    end
    if (bus_b.wr_en) begin
      a = idx_b % 4;
      check_output("b_wr_beat", 64'({bus_b.wr_addr, bus_b.wr_data, bus_b.wr_eol, bus_b.wr_eof}),
                   64'({16'(a), 8'(a + 1), (a % 2 == 1), (a == 3)}));
      idx_b++;
    end
    if (bus_c.wr_en) begin
      a = idx_c % 4;
      check_output("c_wr_beat", 64'({bus_c.wr_addr, bus_c.wr_data, bus_c.wr_eol, bus_c.wr_eof}),
                   64'({16'(a), 8'(a + 1), (a % 2 == 1), (a == 3)}));
      idx_c++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    rd_map = '0; wr_map = '0; busy_map = '0; done_map = '0;
    wr_map_b = '0; done_map_b = '0; busy_map_b = '0;
    wr_map_c = '0; done_map_c = '0; busy_map_c = '0;
    tick();
    tick();
    @(negedge clk);
    check_zero_a("reset_outputs_a");
    check_output("reset_outputs_b", 64'({busy_b, done_b, bus_b.rd_en, bus_b.wr_en, bus_b.rd_addr}), 64'd0);
    check_output("reset_outputs_c", 64'({busy_c, done_c, bus_c.rd_en, bus_c.wr_en, bus_c.wr_addr}), 64'd0);
`ifdef CONV_FRAME_SEQ_STATS_EN
    check_output("reset_stats", 64'({cyc_a, hc_a}), 64'd0);
`endif
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] basic frame with LAT sweeps");
    push_frame();
    apply_stimulus();
    wait_until(20);
    check_output("basic_rd_map", rd_map, span(1, 12));
    check_output("basic_wr_map", wr_map, span(4, 15));
    check_output("basic_busy_map", busy_map, span(1, 16));
    check_output("basic_done_map", done_map, span(16, 16));
    check_output("basic_sb_empty", 64'(sb.size()), 64'd0);
    check_output("lat1_wr_map", wr_map_b, span(3, 6));
    check_output("lat1_done_map", done_map_b, span(7, 7));
    check_output("lat1_busy_map", busy_map_b, span(1, 7));
    check_output("lat8_wr_map", wr_map_c, span(10, 13));
    check_output("lat8_done_map", done_map_c, span(14, 14));
    check_output("lat8_busy_map", busy_map_c, span(1, 14));
    check_output("sweep_write_counts", 64'({16'(idx_b), 16'(idx_c)}), 64'({16'd4, 16'd4}));

    $display("[TB] hold bubbles");
    push_frame();
    apply_stimulus();
    wait_until(3);
    hold = 1'b1;
    @(negedge clk);
    check_output("hold_rd_en", 64'(bus_a.rd_en), 64'd0);
    check_output("hold_rd_addr", 64'(bus_a.rd_addr), 64'd2);
    wait_until(5);
    @(negedge clk);
    check_output("hold_rd_addr_late", 64'(bus_a.rd_addr), 64'd2);
    wait_until(6);
    hold = 1'b0;
    wait_until(22);
    check_output("hold_rd_map", rd_map, span(1, 2) | span(6, 15));
    check_output("hold_wr_map", wr_map, span(4, 5) | span(9, 18));
    check_output("hold_busy_map", busy_map, span(1, 19));
    check_output("hold_done_map", done_map, span(19, 19));
    check_output("hold_sb_empty", 64'(sb.size()), 64'd0);
`ifdef CONV_FRAME_SEQ_STATS_EN
    check_output("stats_after_done", 64'({cyc_a, hc_a}), 64'({24'd19, 16'd3}));
    tick();
    tick();
    tick();
    check_output("stats_idle_stable", 64'({cyc_a, hc_a}), 64'({24'd19, 16'd3}));
`endif

    $display("[TB] reset mid-frame");
    push_frame();
    apply_stimulus();
    wait_until(6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_zero_a("abort_outputs");
`ifdef CONV_FRAME_SEQ_STATS_EN
    check_output("abort_stats", 64'({cyc_a, hc_a}), 64'd0);
`endif
    wait_until(9);
    check_output("abort_no_wr", 64'(wr_map[8:7]), 64'd0);
    check_output("abort_no_rd", 64'(rd_map[8:7]), 64'd0);
    check_output("abort_consumed", 64'(sb.size()), 64'd9);
    sb.delete();
    push_frame();
    apply_stimulus();
    wait_until(20);
    check_output("restart_wr_map", wr_map, span(4, 15));
    check_output("restart_done_map", done_map, span(16, 16));
    check_output("restart_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] start while busy");
    push_frame();
    push_frame();
    apply_stimulus();
    pulse_start_at(5);
    pulse_start_at(16);
    pulse_start_at(17);
    wait_until(36);
    check_output("busy_rd_map", rd_map, span(1, 12) | span(18, 29));
    check_output("busy_wr_map", wr_map, span(4, 15) | span(21, 32));
    check_output("busy_busy_map", busy_map, span(1, 16) | span(18, 33));
    check_output("busy_done_map", done_map, span(16, 16) | span(33, 33));
    check_output("busy_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_frame_seq.md
Name: conv_frame_seq

Overview:
- Frame-level sequencer for the streaming 1x1 convolution datapath.
- On `start`, it walks a W*H source frame buffer in raster order and presents one pixel per cycle to the datapath with a valid strobe.
- It tracks the fixed datapath latency, writes each result to a destination frame buffer at the matching address, and pulses `done` when the last result is stored.
- It replaces the free-running valid counter inside the datapath with an explicit, start-triggered schedule.

Parameters:
- W, 220, frame width in pixels.
- H, 220, frame height in pixels.
- LAT, 2, datapath latency in cycles from `pxl_vld` to the matching `res_in`; legal range 1..8.
- ADDR_W, 16, address width; must satisfy 2^ADDR_W >= W*H.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- hold  in  1  pause source reads this cycle.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last write.
- rd_en  out  1  source buffer read strobe.
- rd_addr  out  ADDR_W  source read address.
- rd_data  in  8  source pixel; valid 1 cycle after `rd_en`.
- pxl_out  out  8  pixel to datapath (`rd_data` registered through).
- pxl_vld  out  1  `pxl_out` is a real pixel.
- res_in  in  8  datapath result, aligned LAT cycles after `pxl_vld`.
- wr_en  out  1  destination write strobe.
- wr_addr  out  ADDR_W  destination address.
- wr_data  out  8  equal to `res_in`.
- wr_eol  out  1  current write is the last column of a row.
- wr_eof  out  1  current write is pixel W*H-1.

Behaviour:
- Reset values, in any state:
  - All outputs 0.
  - Counters 0.
  - Valid shift register cleared.
  - State IDLE.
- Reset mid-frame aborts immediately. No `wr_en` occurs on the cycles following reset, even for pixels already in the datapath.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - `busy`=0.
  - `start`=1 at edge T moves to FEED at T+1 and clears `rd_addr`, `wr_addr`, row and column counters.
- FEED:
  - `busy`=1.
  - Each cycle with `hold`=0: `rd_en`=1 at the current `rd_addr`, and `rd_addr` increments after the edge.
  - With `hold`=1: `rd_en`=0 and `rd_addr` holds.
  - After the read at address W*H-1 issues, go to DRAIN.
  - `hold` is ignored outside FEED.
- Read/valid timing: `pxl_vld` is `rd_en` delayed 1 cycle; `pxl_out` is `rd_data` in that same cycle.
- Write alignment:
  - `wr_en` is `pxl_vld` delayed exactly LAT cycles through a LAT-deep shift register.
  - `wr_data`=`res_in` when `wr_en`=1, else 0.
  - `wr_addr` increments after each `wr_en`.
  - The datapath has no enable, so hold bubbles propagate as `wr_en`=0 cycles; result order is preserved.
- Column/row counting:
  - Column (0..W-1) and row (0..H-1) counters advance on `wr_en`; column wraps to 0 at W-1 and row then increments.
  - `wr_eol`=1 with `wr_en` when column=W-1.
  - `wr_eof`=1 with `wr_en` when `wr_addr`=W*H-1.
- DRAIN: `busy`=1, `rd_en`=0; go to DONE on the edge where the `wr_en` with `wr_eof` is taken.
- DONE: `done`=1 for exactly one cycle, `busy`=1; then IDLE.
- Latency with no hold:
  - First `rd_en` in cycle T+1; first `wr_en` in cycle T+2+LAT.
  - Last `wr_en` in cycle T+W*H+1+LAT; `done` in cycle T+W*H+2+LAT.
- Simultaneous events:
  - `start` while `busy`=1 is ignored.
  - `start` in the DONE cycle is ignored.
  - `start` on the cycle `busy` falls (IDLE) is accepted.
  - `reset` has priority over `start`.
- Widths: `rd_addr` and `wr_addr` never exceed W*H-1, so there is no wrap within a frame.

Optional Feature:
- Macro: CONV_FRAME_SEQ_STATS_EN.
- When defined, two extra outputs are added:
  - `cyc_cnt` [23:0]: counts cycles while `busy`=1; saturates at all-ones; cleared on the `start` acceptance and on `reset`.
  - `hold_cnt` [15:0]: counts FEED cycles with `hold`=1; saturates; cleared the same way.
- Both values remain stable in IDLE until the next accepted `start`.
- When the macro is undefined, these ports and their logic are absent and the rest of the behaviour is identical.

Test Plan:
- Basic frame, W=4, H=3, LAT=2, `hold`=0; source[i]=i+1, `res_in` modelled as `pxl_out` delayed 2. `start` at cycle 0 -> `rd_en` cycles 1..12 at addresses 0..11; `wr_en` cycles 4..15 with `wr_data` 1..12 at addresses 0..11; `wr_eol` at addresses 3, 7, 11; `wr_eof` at cycle 15; `done` at cycle 16; `busy` high cycles 1..16.
- Hold bubbles, same setup, `hold`=1 in cycles 3..5 -> reads pause at address 2; `wr_en` low for 3 cycles, each beginning 3 cycles after the corresponding hold cycle; all 12 writes correct and in order; `done` at cycle 19.
- Reset mid-FEED: `reset` at cycle 6 -> cycle 7 shows all outputs 0; no `wr_en` afterward; a new `start` at cycle 9 gives a clean frame beginning at address 0.
- Start while busy: pulse `start` at cycles 5 and 16 -> both ignored, exactly one frame; `start` at cycle 17 (IDLE) accepted, with the first `rd_en` at cycle 18.
- LAT=1 and LAT=8 sweeps, W=2, H=2 -> first `wr_en` at cycle 2+LAT after `start`; `done` at cycle 6+LAT.
- With CONV_FRAME_SEQ_STATS_EN, basic frame plus 3 hold cycles -> `cyc_cnt`=19, `hold_cnt`=3 after `done`; both hold these values in IDLE.
